// File: rtl/out_pkg.sv
// Shared widths and FSM state type for the output writer.
package out_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned OUT_ADDR_W     = 3;
  localparam int unsigned OUT_NUM_RES    = 8;
  localparam int unsigned OUT_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {OW_IDLE, OW_RUN, OW_DONE} ow_state_t;

endpackage

// File: rtl/output_writer_if.sv
// Datapath-side handshake and RAM write port of the output writer.
interface output_writer_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 3
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              hold;
  logic              ram_write;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;

  modport master (
    output in_valid, in_data, hold,
    input  in_ready, ram_write, ram_addr, ram_data
  );

  modport slave (
    input  in_valid, in_data, hold,
    output in_ready, ram_write, ram_addr, ram_data
  );

endinterface

// File: rtl/result_fifo.sv
// Small synchronous FIFO; push is refused when full, pop when empty.
module result_fifo #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  // Extra MSB on each pointer distinguishes full from empty.
  logic [PtrW:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic                do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[PtrW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (PtrW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (PtrW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q[PtrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/output_writer.sv
// Buffers one frame of results and writes them to the results RAM at addresses 0..NUM_RES-1.
module output_writer
  import out_pkg::*;
#(
  parameter int unsigned DATA_W     = out_pkg::DATA_W,
  parameter int unsigned ADDR_W     = out_pkg::OUT_ADDR_W,
  parameter int unsigned NUM_RES    = out_pkg::OUT_NUM_RES,
  parameter int unsigned FIFO_DEPTH = out_pkg::OUT_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output_writer_if.slave         bus,
  output logic                   busy,
  output logic                   done
);

  // One bit wider than the address so NUM_RES == 2**ADDR_W is representable.
  localparam int unsigned        CntW    = ADDR_W + 1;
  localparam logic [CntW-1:0]    NumResC = CntW'(NUM_RES);

  ow_state_t         state_q, state_d;
  logic [CntW-1:0]   acc_cnt_q, acc_cnt_d;
  logic [CntW-1:0]   wr_cnt_q, wr_cnt_d;
  logic              ram_write_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_data_q;

  logic              fifo_flush, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic              in_ready_c;
  logic [DATA_W-1:0] fifo_head;

  result_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  (bus.in_data),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    acc_cnt_d  = acc_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    fifo_flush = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    in_ready_c = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      OW_IDLE: begin
        if (start) begin
          state_d    = OW_RUN;
          acc_cnt_d  = '0;
          wr_cnt_d   = '0;
          fifo_flush = 1'b1;
        end
      end
      OW_RUN: begin
        busy       = 1'b1;
        // No push-through: a full FIFO refuses input even if it pops this cycle.
        in_ready_c = !fifo_full && (acc_cnt_q < NumResC);
        fifo_push  = bus.in_valid && in_ready_c;
        fifo_pop   = !fifo_empty && !bus.hold;
        if (fifo_push) acc_cnt_d = acc_cnt_q + CntW'(1);
        if (fifo_pop)  wr_cnt_d  = wr_cnt_q + CntW'(1);
        if (wr_cnt_q == NumResC) state_d = OW_DONE;
      end
      OW_DONE: begin
        done    = 1'b1;
        state_d = OW_IDLE;
      end
      default: state_d = OW_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= OW_IDLE;
      acc_cnt_q   <= '0;
      wr_cnt_q    <= '0;
      ram_write_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_cnt_q   <= acc_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      ram_write_q <= fifo_pop;
      if (fifo_pop) begin
        ram_addr_q <= wr_cnt_q[ADDR_W-1:0];
        ram_data_q <= fifo_head;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.ram_write = ram_write_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_data  = ram_data_q;

endmodule
